// File: rtl/banked_mem_cluster_rr.sv
// Multi-port banked memory cluster. Each port has a one-entry request buffer;
// every bank grants at most one buffered request per cycle with a round-robin
// pointer, and per-port ready/valid backpressure holds the losers.
module banked_mem_cluster_rr #(
    parameter int NUM_PORTS = 3,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_wen,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*TAG_W-1:0]    req_tag,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [NUM_PORTS-1:0]          resp_wen,
    output logic [NUM_PORTS*DATA_W-1:0]   resp_rdata,
    output logic [NUM_PORTS*TAG_W-1:0]    resp_tag,
    output logic [CNT_W-1:0]              conflict_count
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam int ROWS   = 1 << ROW_W;
    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Unflattened request inputs
    logic [NUM_PORTS-1:0][ADDR_W-1:0] in_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] in_wdata;
    logic [NUM_PORTS-1:0][TAG_W-1:0]  in_tag;
    assign in_addr  = req_addr;
    assign in_wdata = req_wdata;
    assign in_tag   = req_tag;

    // Request buffers
    logic [NUM_PORTS-1:0]             bv_q, bv_d, bwen_q, bwen_d;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] baddr_q, baddr_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] bwdata_q, bwdata_d;
    logic [NUM_PORTS-1:0][TAG_W-1:0]  btag_q, btag_d;
    logic [NUM_PORTS-1:0][BANK_W-1:0] bbank;
    logic [NUM_PORTS-1:0][ROW_W-1:0]  brow;

    // Arbitration state and results
    logic [NUM_BANKS-1:0][PTR_W-1:0]     rr_q, rr_d;
    logic [NUM_BANKS-1:0][PTR_W-1:0]     gnt_port;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] gnt_oh;
    logic [NUM_BANKS-1:0]                gnt_any;
    logic [NUM_PORTS-1:0]                grant;

    // Responses and conflict counter
    logic [NUM_PORTS-1:0]             rv_q, rwen_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q;
    logic [NUM_PORTS-1:0][TAG_W-1:0]  rtag_q;
    logic [CNT_W-1:0]                 cc_q, cc_d;

    // Bank storage, deliberately not reset
    logic [DATA_W-1:0] mem_q [NUM_BANKS][ROWS];

    // Split buffered addresses into bank select (top bits) and row
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bbank[p] = baddr_q[p][ADDR_W-1 -: BANK_W];
            brow[p]  = baddr_q[p][ROW_W-1:0];
        end
    end

    // Per-bank round robin: winner is the candidate closest upward from rr_q
    always_comb begin
        int best, d;
        gnt_oh   = '0;
        gnt_port = '0;
        gnt_any  = '0;
        grant    = '0;
        best     = NUM_PORTS;
        d        = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            best = NUM_PORTS;
            for (int p = 0; p < NUM_PORTS; p++) begin
                d = p - int'(rr_q[b]);
                if (d < 0) d = d + NUM_PORTS;
                if (bv_q[p] && bbank[p] == BANK_W'(b) && d < best) begin
                    best        = d;
                    gnt_oh[b]   = '0;
                    gnt_oh[b][p] = 1'b1;
                    gnt_port[b] = PTR_W'(p);
                end
            end
            gnt_any[b] = (best < NUM_PORTS);
            grant      = grant | gnt_oh[b];
        end
    end

    assign req_ready = ~bv_q | grant;

    // Next pointer, buffer load/clear and saturating conflict count
    always_comb begin
        rr_d     = rr_q;
        bv_d     = bv_q;
        bwen_d   = bwen_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        btag_d   = btag_q;
        cc_d     = cc_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (gnt_any[b])
                rr_d[b] = (gnt_port[b] == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_port[b] + PTR_W'(1);
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req_valid[p] && req_ready[p]) begin
                bv_d[p]     = 1'b1;
                bwen_d[p]   = req_wen[p];
                baddr_d[p]  = in_addr[p];
                bwdata_d[p] = in_wdata[p];
                btag_d[p]   = in_tag[p];
            end else if (grant[p]) begin
                bv_d[p] = 1'b0;
            end
        end
        if (|(bv_q & ~grant) && cc_q != '1)
            cc_d = cc_q + CNT_W'(1);
    end

    // Control and buffer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q     <= '0;
            bv_q     <= '0;
            bwen_q   <= '0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            btag_q   <= '0;
            cc_q     <= '0;
        end else begin
            rr_q     <= rr_d;
            bv_q     <= bv_d;
            bwen_q   <= bwen_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            btag_q   <= btag_d;
            cc_q     <= cc_d;
        end
    end

    // Bank writes; the grant one-hot guarantees one writer per bank
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++)
            for (int p = 0; p < NUM_PORTS; p++)
                if (gnt_oh[b][p] && bwen_q[p])
                    mem_q[b][brow[p]] <= bwdata_q[p];
    end

    // Registered responses: read data sampled before this edge's write lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rv_q    <= '0;
            rwen_q  <= '0;
            rdata_q <= '0;
            rtag_q  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rv_q[p]    <= grant[p];
                rwen_q[p]  <= grant[p] & bwen_q[p];
                rtag_q[p]  <= grant[p] ? btag_q[p] : '0;
                rdata_q[p] <= (grant[p] && !bwen_q[p]) ? mem_q[bbank[p]][brow[p]] : '0;
            end
        end
    end

    assign resp_valid     = rv_q;
    assign resp_wen       = rwen_q;
    assign resp_rdata     = rdata_q;
    assign resp_tag       = rtag_q;
    assign conflict_count = cc_q;
endmodule
